// File: rtl/shift_defs_pkg.sv
// Shared shift definitions: MIPS-style SPECIAL funct codes, FSM states and the
// shift decode used by both the sequential shifter and the ALU decode.
package shift_defs;

   localparam logic [5:0] OP_SPECIAL = 6'h00;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic is_shift;
      logic use_rs;
      logic dir_right;
      logic arith;
   } shift_dec_t;

   function automatic shift_dec_t decode_shift(input logic [5:0] opcode,
                                               input logic [5:0] funct);
      shift_dec_t d;
      d = '0;
      if (opcode == OP_SPECIAL) begin
         unique case (funct)
            F_SLL:   d = '{is_shift: 1'b1, use_rs: 1'b0, dir_right: 1'b0, arith: 1'b0};
            F_SRL:   d = '{is_shift: 1'b1, use_rs: 1'b0, dir_right: 1'b1, arith: 1'b0};
            F_SRA:   d = '{is_shift: 1'b1, use_rs: 1'b0, dir_right: 1'b1, arith: 1'b1};
            F_SLLV:  d = '{is_shift: 1'b1, use_rs: 1'b1, dir_right: 1'b0, arith: 1'b0};
            F_SRLV:  d = '{is_shift: 1'b1, use_rs: 1'b1, dir_right: 1'b1, arith: 1'b0};
            F_SRAV:  d = '{is_shift: 1'b1, use_rs: 1'b1, dir_right: 1'b1, arith: 1'b1};
            default: d = '0;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift stage: left zero-fill, or right with either
// zero fill or replication of the current MSB.
module shift_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] data,
   input  logic         direction,
   input  logic         arith,
   output logic [W-1:0] shifted
);

   always_comb begin
      shifted = '0;
      if (direction) begin
         shifted = {(arith & data[W-1]), data[W-1:1]};
      end else begin
         shifted = {data[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shifter: accepts one shift operation, shifts one bit per clock,
// then holds the result until the consumer takes it.
module shift_seq_ctrl
   import shift_defs::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   input  logic [4:0]   shamt,
   input  logic [W-1:0] rs_val,
   input  logic [W-1:0] data_in,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] data_out,
   output logic         busy
);

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [W-1:0] data_q, data_d;
   logic         dir_q, dir_d;
   logic         arith_q, arith_d;

   shift_dec_t   dec;
   logic [4:0]   amt;
   logic [W-1:0] step_out;
   logic         rs_unused;

   assign rs_unused = ^rs_val[W-1:5];

   assign dec = decode_shift(opcode, funct);

   always_comb begin
      amt = 5'd0;
      if (dec.is_shift) begin
         amt = dec.use_rs ? rs_val[4:0] : shamt;
      end
   end

   shift_step #(.W(W)) u_step (
      .data      (data_q),
      .direction (dir_q),
      .arith     (arith_q),
      .shifted   (step_out)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dir_d   = dir_q;
      arith_d = arith_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               data_d  = data_in;
               dir_d   = dec.dir_right;
               arith_d = dec.arith;
               if (amt == 5'd0) begin
                  cnt_d   = 5'd0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = amt;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            data_d = step_out;
            cnt_d  = cnt_q - 5'd1;
            // cnt of 0 here is unreachable; treat it like the last step
            if (cnt_q <= 5'd1) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         arith_q <= arith_d;
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign busy        = !start_ready;
   assign res_valid   = (state_q == ST_DONE);
   assign data_out    = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected results and
// arrival cycles, an independent negedge monitor pops and compares them.
module tb_shift_seq_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic [4:0]    shamt = '0;
   logic [W-1:0]  rs_val = '0;
   logic [W-1:0]  data_in = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  data_out;
   logic          busy;

   shift_seq_ctrl #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .opcode      (opcode),
      .funct       (funct),
      .shamt       (shamt),
      .rs_val      (rs_val),
      .data_in     (data_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .data_out    (data_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int unsigned exp_cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned passed = 0;
   int unsigned cyc = 0;
   int          bp_mode = 0;
   bit          in_result = 1'b0;
   logic [31:0] held = '0;
   exp_t        e_mon;

   always @(negedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: MIPS shift semantics computed with native operators.
   function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] sa, input logic [31:0] rs,
                                 input logic [31:0] din,
                                 output logic [31:0] res, output int unsigned amt);
      res = din;
      amt = 0;
      if (op == 6'h00) begin
         case (fn)
            6'h00: begin amt = sa;       res = din << amt; end
            6'h02: begin amt = sa;       res = din >> amt; end
            6'h03: begin amt = sa;       res = 32'($signed(din) >>> amt); end
            6'h04: begin amt = rs % 32;  res = din << amt; end
            6'h06: begin amt = rs % 32;  res = din >> amt; end
            6'h07: begin amt = rs % 32;  res = 32'($signed(din) >>> amt); end
            default: ;
         endcase
      end
   endfunction

   // Monitor: compares each result on its first valid cycle and while it is held.
   always @(negedge clk) begin
      if (res_valid) begin
         if (in_result) begin
            check("hold", data_out, held);
         end else if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got res_valid=1 data=%h expected no result (cycle %0d)",
                     data_out, cyc);
            in_result = 1'b1;
            held      = data_out;
         end else begin
            e_mon = sb.pop_front();
            check("latency", cyc, e_mon.exp_cyc);
            check("data", data_out, e_mon.data);
            in_result = 1'b1;
            held      = e_mon.data;
         end
      end else if (in_result) begin
         checks++;
         $display("FAIL valid_dropped: got res_valid=0 expected 1 (cycle %0d)", cyc);
         in_result = 1'b0;
      end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
         e_mon = sb.pop_front();
         checks++;
         $display("FAIL result_timeout: got res_valid=0 expected 1 by cycle %0d", e_mon.exp_cyc);
      end
      if (bp_mode == 1)      res_ready = 1'b0;
      else if (bp_mode == 2) res_ready = 1'b1;
      else                   res_ready = ($urandom_range(0, 2) != 0);
      if (res_valid && res_ready) in_result = 1'b0;
   end

   task automatic wait_ready(output int unsigned k, output bit ok);
      int unsigned n = 0;
      @(negedge clk);
      while (!start_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      ok = start_ready;
      k  = cyc;
      if (!ok) begin
         checks++;
         $display("FAIL ready_timeout: got start_ready=0 expected 1 (cycle %0d)", cyc);
      end
   endtask

   task automatic drive_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                           input logic [31:0] rs, input logic [31:0] din, input bit junk);
      logic [31:0] r;
      int unsigned amt, k;
      bit ok;
      wait_ready(k, ok);
      if (!ok) return;
      opcode = op; funct = fn; shamt = sa; rs_val = rs; data_in = din;
      start_valid = 1'b1;
      model(op, fn, sa, rs, din, r, amt);
      sb.push_back('{r, k + 1 + amt});
      for (int i = 0; i < int'(amt); i++) begin
         @(negedge clk);
         if (junk) begin
            start_valid = 1'($urandom_range(0, 1));
            opcode  = 6'($urandom);
            funct   = 6'($urandom);
            shamt   = 5'($urandom);
            rs_val  = $urandom;
            data_in = $urandom;
         end
      end
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      int unsigned amt, k, n;
      bit ok;
      logic [5:0] fn_tab [6];
      fn_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", res_valid, 0);
      check("rst_data", data_out, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", start_ready, 1);
      check("rst_busy", busy, 0);

      // Directed cases
      drive_op(6'h00, 6'h00, 5'd4,  32'h0,        32'h0000_0001, 1'b0);
      drive_op(6'h00, 6'h03, 5'd31, 32'h0,        32'h8000_0000, 1'b1);
      drive_op(6'h00, 6'h06, 5'd9,  32'h0000_0024, 32'hF000_0000, 1'b1);
      drive_op(6'h08, 6'h00, 5'd5,  32'h0,        32'h1234_5678, 1'b0);
      drive_op(6'h00, 6'h00, 5'd0,  32'h0,        32'hCAFE_F00D, 1'b0);
      drive_op(6'h00, 6'h02, 5'd31, 32'h0,        32'hFFFF_FFFF, 1'b1);
      drive_op(6'h00, 6'h07, 5'd0,  32'hFFFF_FFE0, 32'h8000_0001, 1'b1);

      // Backpressure: result held 5 cycles while a new op waits on start_valid
      wait_ready(k, ok);
      if (ok) begin
         bp_mode = 1;
         opcode = 6'h00; funct = 6'h00; shamt = 5'd2; rs_val = '0; data_in = 32'h0000_00F1;
         start_valid = 1'b1;
         model(6'h00, 6'h00, 5'd2, 32'h0, 32'h0000_00F1, r, amt);
         sb.push_back('{r, k + 1 + amt});
         @(negedge clk);
         start_valid = 1'b0;
         repeat (2) @(negedge clk);
         opcode = 6'h00; funct = 6'h03; shamt = 5'd3; rs_val = '0; data_in = 32'h8000_0100;
         start_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_ready", start_ready, 0);
         end
         @(posedge clk);
         bp_mode = 2;
         @(negedge clk);
         check("bp_ready_handoff", start_ready, 0);
         model(6'h00, 6'h03, 5'd3, 32'h0, 32'h8000_0100, r, amt);
         sb.push_back('{r, cyc + 2 + amt});
         @(negedge clk);
         check("bp_ready_after", start_ready, 1);
         @(negedge clk);
         start_valid = 1'b0;
         @(posedge clk);
         bp_mode = 0;
      end

      // Reset mid-SHIFT aborts the operation
      wait_ready(k, ok);
      if (ok) begin
         opcode = 6'h00; funct = 6'h00; shamt = 5'd20; rs_val = '0; data_in = 32'h0000_0001;
         start_valid = 1'b1;
         @(negedge clk);
         start_valid = 1'b0;
         repeat (4) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("abort_valid", res_valid, 0);
         check("abort_data", data_out, 0);
         check("abort_ready", start_ready, 1);
         @(negedge clk);
         check("abort_ready2", start_ready, 1);
         repeat (25) @(negedge clk);
      end

      // Randomized operations
      for (int i = 0; i < 120; i++) begin
         logic [5:0] op, fn;
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'h00;
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
         drive_op(op, fn, 5'($urandom), $urandom, $urandom, 1'b1);
      end

      n = 0;
      while ((sb.size() > 0 || in_result) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0 || in_result) begin
         checks++;
         $display("FAIL drain: got %0d pending results expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  requester presents an operation.
REQ-005 SHALL have port start_ready  output  1  block can accept an operation.
REQ-006 SHALL have port opcode  input  6  instruction opcode.
REQ-007 SHALL have port funct  input  6  instruction funct field.
REQ-008 SHALL have port shamt  input  5  immediate shift amount.
REQ-009 SHALL have port rs_val  input  W  variable-shift source; only bits [4:0] are used.
REQ-010 SHALL have port data_in  input  W  operand to shift.
REQ-011 SHALL have port res_valid  output  1  data_out holds a completed result.
REQ-012 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port data_out  output  W  result register.
REQ-014 SHALL have port busy  output  1  high in SHIFT or DONE.

Function
REQ-015 SHALL implement FSM IDLE, SHIFT, DONE; start_ready = (state==IDLE); busy = !start_ready.
REQ-016 SHALL accept an operation only on an edge where start_valid && start_ready; it SHALL sample opcode, funct, shamt, rs_val and data_in on that edge only.
REQ-017 SHALL decode opcode==0x00 with funct in {0x00 SLL, 0x02 SRL, 0x03 SRA} as using amt=shamt, and funct in {0x04 SLLV, 0x06 SRLV, 0x07 SRAV} as using amt=rs_val[4:0].
REQ-018 SHALL treat any other opcode/funct combination as pass-through: data_out=data_in, amt treated as 0.
REQ-019 On accept with amt==0, SHALL load data_out=data_in and go to DONE, so res_valid is high in the cycle after the accept edge.
REQ-020 On accept with amt>0, SHALL load data_out=data_in and cnt=amt, then go to SHIFT.
REQ-021 In SHIFT, SHALL shift data_out by exactly one bit per edge and decrement cnt; the edge on which cnt==1 SHALL move to DONE.
REQ-022 With accept edge t0, res_valid SHALL first be high in the cycle following edge t0+amt.
REQ-023 SHALL zero-fill for SLL/SLLV and SRL/SRLV, and fill with the current bit W-1 for SRA/SRAV.
REQ-024 For amt >= W, SHALL saturate naturally: SLL/SRL result 0, SRA result all copies of the sign bit.
REQ-025 In DONE, res_valid SHALL be 1 and data_out SHALL hold stable until the edge where res_ready==1; that edge SHALL move to IDLE.
REQ-026 SHALL NOT accept a new operation on the same edge as result handoff; the earliest next accept is the following edge.
REQ-027 SHALL ignore start_valid and all operand inputs while busy.

Reset
REQ-028 On an edge with rst==1, SHALL set state=IDLE, cnt=0, data_out=0 and res_valid=0, overriding all other activity.
REQ-029 rst asserted in SHIFT or DONE SHALL abort the operation; no res_valid for it SHALL ever appear.
REQ-030 start_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Funct constants (SLL, SRL, SRA, SLLV, SRLV, SRAV) and FSM state encodings SHALL live in a shared shift_defs package/header, also used by the ALU decode.
REQ-032 The single-bit shift stage SHALL be a combinational sub-module shift_step (inputs: data, direction, arith; output: shifted data); the FSM and counter SHALL stay in shift_seq_ctrl.

Verification
REQ-033 SLL: data_in=0x00000001, funct=0x00, shamt=4 -> data_out=0x00000010; res_valid first high 4 cycles after the cycle following the accept edge.
REQ-034 SRA: data_in=0x80000000, funct=0x03, shamt=31 -> data_out=0xFFFFFFFF after 31 shift edges.
REQ-035 SRLV: data_in=0xF0000000, rs_val=0x00000024, shamt=9 (ignored) -> data_out=0x0F000000.
REQ-036 Pass-through: opcode=0x08, and separately SLL with shamt=0 -> data_out=data_in with res_valid in the cycle after accept.
REQ-037 Backpressure: hold res_ready=0 for 5 cycles in DONE with start_valid=1 -> data_out stable, start_ready=0, no new accept until after handoff.
REQ-038 Reset mid-SHIFT (shamt=20, rst at cycle 5) -> IDLE next cycle, res_valid=0, data_out=0, start_ready=1 after rst drops.
